// File: rtl/spark_sequencer.sv
// Fires one coil per valid change of the igniter position: fixed dwell, then a
// recovery gap, with a one-deep pending slot and a sticky overrun flag.
module spark_sequencer #(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic       sys_clk,
  input  logic       clr_n,
  input  logic [2:0] position,
  input  logic       enable,
  output logic [7:0] coil,
  output logic       busy,
  output logic [7:0] fire_count,
  output logic       overrun
);

  typedef enum logic [1:0] {IDLE, DWELL, GAP} state_e;

  localparam logic [3:0] DWELL_LOAD = 4'(DWELL_CYCLES - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] tgt_q, tgt_d;
  logic       pend_v_q, pend_v_d;
  logic [2:0] pend_pos_q, pend_pos_d;
  logic [2:0] pos_q;
  logic       primed_q;
  logic [7:0] coil_q, coil_d;
  logic       busy_q, busy_d;
  logic [7:0] fire_q, fire_d;
  logic       overrun_q, overrun_d;

  logic       ev;
  logic       start;
  logic [2:0] start_pos;

  always_comb begin
    ev         = primed_q && enable && (position != pos_q);
    state_d    = state_q;
    cnt_d      = cnt_q;
    tgt_d      = tgt_q;
    pend_v_d   = pend_v_q;
    pend_pos_d = pend_pos_q;
    fire_d     = fire_q;
    overrun_d  = overrun_q;
    start      = 1'b0;
    start_pos  = position;

    case (state_q)
      IDLE: begin
        // A slot loaded on the final GAP edge is drained from IDLE rather than lost.
        if (pend_v_q) begin
          start      = 1'b1;
          start_pos  = pend_pos_q;
          pend_v_d   = ev;
          pend_pos_d = position;
        end else if (ev) begin
          start = 1'b1;
        end
      end
      DWELL: begin
        if (cnt_q == 4'd0) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      GAP: begin
        if (cnt_q == 4'd0) begin
          if (pend_v_q) begin
            start     = 1'b1;
            start_pos = pend_pos_q;
            pend_v_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // In GAP, start means the slot is being consumed, so a new event is not an overrun.
    if ((state_q != IDLE) && ev) begin
      if (pend_v_q && !start) overrun_d = 1'b1;
      pend_v_d   = 1'b1;
      pend_pos_d = position;
    end

    if (start) begin
      state_d = DWELL;
      cnt_d   = DWELL_LOAD;
      tgt_d   = start_pos;
      fire_d  = fire_q + 8'd1;
    end

    coil_d = (state_d == DWELL) ? (8'd1 << tgt_d) : 8'd0;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sys_clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      tgt_q      <= 3'd0;
      pend_v_q   <= 1'b0;
      pend_pos_q <= 3'd0;
      pos_q      <= 3'd0;
      primed_q   <= 1'b0;
      coil_q     <= 8'd0;
      busy_q     <= 1'b0;
      fire_q     <= 8'd0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tgt_q      <= tgt_d;
      pend_v_q   <= pend_v_d;
      pend_pos_q <= pend_pos_d;
      pos_q      <= position;
      primed_q   <= 1'b1;
      coil_q     <= coil_d;
      busy_q     <= busy_d;
      fire_q     <= fire_d;
      overrun_q  <= overrun_d;
    end
  end

  assign coil       = coil_q;
  assign busy       = busy_q;
  assign fire_count = fire_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spark_sequencer.sv
// Scoreboard bench for spark_sequencer: per-cycle expected coil values are
// queued as stimulus is driven and popped as each cycle is sampled.
module tb_spark_sequencer;

  logic       sys_clk = 1'b0;
  logic       clr_n;
  logic [2:0] position;
  logic       enable;
  logic [7:0] coil;
  logic       busy;
  logic [7:0] fire_count;
  logic       overrun;

  int         total = 0;
  int         bad = 0;
  logic [7:0] expFire = 8'd0;
  logic [7:0] expQ[$];
  logic [7:0] expCoil;

  spark_sequencer #(.DWELL_CYCLES(4), .GAP_CYCLES(2)) dut (
    .sys_clk(sys_clk),
    .clr_n(clr_n),
    .position(position),
    .enable(enable),
    .coil(coil),
    .busy(busy),
    .fire_count(fire_count),
    .overrun(overrun)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_fire(input logic [2:0] p);
    repeat (4) expQ.push_back(8'd1 << p);
    repeat (2) expQ.push_back(8'd0);
    expFire = expFire + 8'd1;
  endtask

  task automatic test_reset();
    clr_n = 1'b0; enable = 1'b1; position = 3'd3;
    #1;
    total++;
    if (coil !== 8'd0 || busy !== 1'b0 || fire_count !== 8'd0 || overrun !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_state coil=%h busy=%b fc=%0d ovr=%b want all zero", coil, busy, fire_count, overrun);
    end
    step(); step();
    clr_n = 1'b1;
    repeat (5) expQ.push_back(8'd0);
    while (expQ.size() > 0) begin
      step();
      expCoil = expQ.pop_front();
      total++;
      if (coil !== expCoil) begin
        bad++;
        $display("[TB] FAIL reset_hold_coil got=%h want=%h", coil, expCoil);
      end
    end
    total++;
    if (fire_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL reset_hold_count got=%0d want=0", fire_count);
    end
  endtask

  task automatic test_single();
    logic expBusy;
    position = 3'd5;
    push_fire(3'd5);
    expQ.push_back(8'd0);
    for (int i = 0; i < 7; i++) begin
      step();
      expCoil = expQ.pop_front();
      expBusy = (i < 6);
      total++;
      if (coil !== expCoil) begin
        bad++;
        $display("[TB] FAIL single_coil cyc=%0d got=%h want=%h", i, coil, expCoil);
      end
      total++;
      if (busy !== expBusy) begin
        bad++;
        $display("[TB] FAIL single_busy cyc=%0d got=%b want=%b", i, busy, expBusy);
      end
    end
    total++;
    if (fire_count !== expFire) begin
      bad++;
      $display("[TB] FAIL single_count got=%0d want=%0d", fire_count, expFire);
    end
  endtask

  task automatic test_back_to_back();
    int i;
    position = 3'd2;
    push_fire(3'd2);
    push_fire(3'd6);
    expQ.push_back(8'd0);
    i = 0;
    while (expQ.size() > 0) begin
      step();
      expCoil = expQ.pop_front();
      total++;
      if (coil !== expCoil) begin
        bad++;
        $display("[TB] FAIL b2b_coil cyc=%0d got=%h want=%h", i, coil, expCoil);
      end
      if (i == 1) position = 3'd6;
      i++;
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("[TB] FAIL b2b_overrun got=%b want=0", overrun);
    end
    total++;
    if (fire_count !== expFire) begin
      bad++;
      $display("[TB] FAIL b2b_count got=%0d want=%0d", fire_count, expFire);
    end
  endtask

  task automatic test_overrun();
    int i;
    position = 3'd3;
    push_fire(3'd3);
    push_fire(3'd4);
    expQ.push_back(8'd0);
    i = 0;
    while (expQ.size() > 0) begin
      step();
      expCoil = expQ.pop_front();
      total++;
      if (coil !== expCoil) begin
        bad++;
        $display("[TB] FAIL ovr_coil cyc=%0d got=%h want=%h", i, coil, expCoil);
      end
      if (i == 0) position = 3'd1;
      if (i == 1) position = 3'd2;
      if (i == 2) position = 3'd4;
      i++;
    end
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovr_flag got=%b want=1", overrun);
    end
    total++;
    if (fire_count !== expFire) begin
      bad++;
      $display("[TB] FAIL ovr_count got=%0d want=%0d", fire_count, expFire);
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    repeat (4) expQ.push_back(8'd0);
    for (int i = 0; i < 4; i++) begin
      if (i < 3) position = 3'(i);
      step();
      expCoil = expQ.pop_front();
      total++;
      if (coil !== expCoil) begin
        bad++;
        $display("[TB] FAIL disabled_coil cyc=%0d got=%h want=%h", i, coil, expCoil);
      end
    end
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("[TB] FAIL overrun_sticky got=%b want=1", overrun);
    end
    enable = 1'b1;
    step();
    position = 3'd7;
    push_fire(3'd7);
    while (expQ.size() > 0) begin
      step();
      expCoil = expQ.pop_front();
      total++;
      if (coil !== expCoil) begin
        bad++;
        $display("[TB] FAIL enable_coil got=%h want=%h", coil, expCoil);
      end
    end
    total++;
    if (fire_count !== expFire) begin
      bad++;
      $display("[TB] FAIL enable_count got=%0d want=%0d", fire_count, expFire);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    clr_n = 1'b0; position = 3'd0;
    step();
    clr_n = 1'b1;
    expFire = 8'd0;
    step();
    for (int k = 1; k <= 255; k++) begin
      position = (k % 2 == 1) ? 3'd7 : 3'd0;
      expFire = expFire + 8'd1;
      repeat (7) step();
    end
    total++;
    if (fire_count !== 8'd255) begin
      bad++;
      $display("[TB] FAIL wrap_count255 got=%0d want=255", fire_count);
    end
    position = 3'd0;
    expFire = expFire + 8'd1;
    expQ.push_back(8'h01);
    expQ.push_back(8'h01);
    step();
    expCoil = expQ.pop_front();
    total++;
    if (coil !== expCoil) begin
      bad++;
      $display("[TB] FAIL wrap_coil got=%h want=%h", coil, expCoil);
    end
    total++;
    if (fire_count !== expFire) begin
      bad++;
      $display("[TB] FAIL wrap_count got=%0d want=%0d", fire_count, expFire);
    end
    position = 3'd3;
    step();
    expCoil = expQ.pop_front();
    total++;
    if (coil !== expCoil) begin
      bad++;
      $display("[TB] FAIL mid_dwell_coil got=%h want=%h", coil, expCoil);
    end
    #2;
    clr_n = 1'b0;
    #1;
    total++;
    if (coil !== 8'd0 || busy !== 1'b0 || fire_count !== 8'd0 || overrun !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset coil=%h busy=%b fc=%0d ovr=%b want all zero", coil, busy, fire_count, overrun);
    end
    step();
    clr_n = 1'b1;
    repeat (8) expQ.push_back(8'd0);
    while (expQ.size() > 0) begin
      step();
      expCoil = expQ.pop_front();
      total++;
      if (coil !== expCoil) begin
        bad++;
        $display("[TB] FAIL post_reset_coil got=%h want=%h", coil, expCoil);
      end
    end
    total++;
    if (fire_count !== 8'd0) begin
      bad++;
      $display("[TB] FAIL post_reset_count got=%0d want=0", fire_count);
    end
  endtask

  initial begin
    $display("[TB] spark_sequencer bench start");
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_enable();
    test_wrap_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spark_sequencer.md
# spark_sequencer

Downstream consumer of the igniter's 3-bit `position` output. Each valid change of `position` fires one of eight coil outputs, one-hot, for a fixed dwell time, followed by a mandatory recovery gap. Events that arrive during a firing are held in a one-deep pending slot; when that slot is overwritten, a sticky overrun is flagged. A wrapping fire counter supports bring-up and debug.

## Interface
- `DWELL_CYCLES`, default 4: coil high time in `sys_clk` cycles; legal range 1..15.
- `GAP_CYCLES`, default 2: all-coils-low recovery time after each dwell; legal range 1..15.
- `sys_clk`  in  1  system clock; all state updates on the rising edge.
- `clr_n`  in  1  reset, asynchronous and active-low.
- `position`  in  3  crank position from the igniter, synchronous to `sys_clk`.
- `enable`  in  1  arms event capture when high.
- `coil`  out  8  one-hot coil drive; `coil[i]` is high while position i is firing.
- `busy`  out  1  high during DWELL and GAP.
- `fire_count`  out  8  number of firings started, modulo 256.
- `overrun`  out  1  sticky; set when a pending event is overwritten.

## Operation
- Reset (`clr_n` = 0) takes effect immediately, asynchronously:
  - state = IDLE; `coil` = 0, `busy` = 0, `fire_count` = 0, `overrun` = 0.
  - pending slot empty; `pos_q` = 0; `primed` = 0.
- Position tracking:
  - `pos_q` registers `position` every cycle.
  - `primed` goes to 1 on the first edge after reset.
- Event definition: `primed` = 1, `enable` = 1, and `position` != `pos_q` in the current cycle.
  - The event target is the current `position`.
  - The first sample after reset is never an event.
  - While `enable` = 0, events are discarded and not queued. Any in-progress firing and any already-pending event still complete.
- State machine (all outputs registered):
  - **IDLE**: on an event, go to DWELL with target = `position`.
  - **DWELL**: `coil` = 1 << target, `busy` = 1. After DWELL_CYCLES cycles, go to GAP.
  - **GAP**: `coil` = 0, `busy` = 1. After GAP_CYCLES cycles:
    - if the pending slot is valid, go straight to DWELL with target = pending;
    - otherwise go to IDLE.
- Pending slot (one entry, position plus valid bit):
  - Loaded by any event that occurs in DWELL or GAP.
  - If the slot is already valid and is not being consumed on this edge, the new event overwrites it and sets `overrun`.
  - On the edge where GAP consumes the slot, a simultaneous new event is stored in the freed slot. No overrun in this case.
- `fire_count` increments on every entry into DWELL and wraps 255 → 0.
- `overrun` clears only on reset.
- Counters are 4 bits wide. The DWELL and GAP counters reload on every state entry.

## Timing
- Start latency: event present in cycle N → `coil`/`busy` high from edge N for exactly DWELL_CYCLES cycles. `fire_count` updates at edge N.
- Back-to-back firing: on a pending restart, the last GAP cycle is followed directly by DWELL (no IDLE cycle).
  - `coil` is never high for two positions at once.
  - `coil` is never high in adjacent cycles across a restart; GAP ≥ 1 guarantees this.
- Minimum period between coil rising edges: DWELL_CYCLES + GAP_CYCLES cycles.
- A position that changes and then returns to its original value produces two events.
- Position wrap 7 → 0 is an ordinary change; target 0 drives `coil` = 8'h01.
- Reset asserted mid-DWELL: `coil` goes to 0 asynchronously and the pending event is lost. After release, the first sample re-primes and does not fire.

## Test plan
- Reset, then hold `position` = 3 with `enable` = 1 → no firing. `coil` = 0, `fire_count` = 0.
- Defaults; `position` 3 → 5 at edge N:
  - `coil` = 8'h20 for edges N..N+3, then 0 for 2 cycles;
  - `busy` high for 6 cycles; `fire_count` = 1.
- Change to 6 during DWELL:
  - coil 8'h40 rises exactly 6 cycles after the first rise, with no idle gap beyond GAP;
  - `overrun` = 0; `fire_count` = 2.
- Three changes (1, 2, 4) during one firing → only position 4 fires next; `overrun` = 1 and stays 1 until reset.
- `enable` = 0 while `position` steps 0 → 1 → 2 → no firing. Set `enable` = 1, then step to 7 → `coil` = 8'h80.
- Drive 256 firings via 0 ↔ 7 toggles → `fire_count` wraps to 0. Assert `clr_n` mid-DWELL → `coil` drops to 0 without waiting for a clock edge.
